// File: rtl/inv_chain_bist_ctrl_if.sv
// Control/status bundle between the test/config logic (master) and the
// inverter-chain BIST sequencer (slave).
interface inv_chain_bist_ctrl_if #(
  parameter int CNT_W  = 16,
  parameter int WAIT_W = 4
);
  logic              start;
  logic [CNT_W-1:0]  num_vectors;
  logic [WAIT_W-1:0] settle_cycles;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output start, num_vectors, settle_cycles,
    input  busy, done, pass, err_count
  );

  modport slave (
    input  start, num_vectors, settle_cycles,
    output busy, done, pass, err_count
  );
endinterface

// File: rtl/inv_chain_bist_ctrl.sv
// BIST sequencer for the flop-launched inverter delay chain. Each vector
// toggles the chain input, waits a latched number of settle cycles, then
// compares the chain output with the polarity implied by the cell count and
// accumulates a saturating mismatch count. A run ends with done/pass held
// until the next accepted start.
module inv_chain_bist_ctrl #(
  parameter int N      = 3,
  parameter int CNT_W  = 16,
  parameter int WAIT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  inv_chain_bist_ctrl_if.slave ctrl,
  output logic                 chain_in_o,
  input  logic                 chain_out_i
);

  // An odd number of inverters flips the launched value.
  localparam logic EXP_POL = 1'(N % 2);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } state_e;

  state_e            state_q, state_d;
  logic              chain_in_q, chain_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]  num_vec_q, num_vec_d;
  logic [WAIT_W-1:0] settle_q, settle_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [WAIT_W-1:0] settle_eff;
  logic              mismatch;
  logic [CNT_W-1:0]  err_after_check;
  logic              last_vec;

  // A settle value of zero would skip the chain's own input register.
  assign settle_eff = (ctrl.settle_cycles == '0) ? WAIT_W'(1) : ctrl.settle_cycles;

  assign mismatch        = chain_out_i != (chain_in_q ^ EXP_POL);
  assign err_after_check = (mismatch && (err_q != '1)) ? err_q + CNT_W'(1) : err_q;
  assign last_vec        = (vec_cnt_q + CNT_W'(1)) == num_vec_q;

  // State and datapath registers; every register returns to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      chain_in_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      vec_cnt_q  <= '0;
      num_vec_q  <= '0;
      settle_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      chain_in_q <= chain_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      vec_cnt_q  <= vec_cnt_d;
      num_vec_q  <= num_vec_d;
      settle_q   <= settle_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic: accept a run in IDLE, then cycle drive/settle/check per vector.
  always_comb begin
    state_d    = state_q;
    chain_in_d = chain_in_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    vec_cnt_d  = vec_cnt_q;
    num_vec_d  = num_vec_q;
    settle_d   = settle_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (ctrl.start) begin
          num_vec_d = ctrl.num_vectors;
          settle_d  = settle_eff;
          err_d     = '0;
          vec_cnt_d = '0;
          if (ctrl.num_vectors == '0) begin
            done_d = 1'b1;
            pass_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = DRIVE;
          end
        end
      end

      DRIVE: begin
        chain_in_d = ~chain_in_q;
        wait_cnt_d = settle_q;
        state_d    = SETTLE;
      end

      SETTLE: begin
        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        if (wait_cnt_q == WAIT_W'(1)) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        err_d = err_after_check;
        if (last_vec) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_after_check == '0);
          state_d = IDLE;
        end else begin
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
          state_d   = DRIVE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign chain_in_o     = chain_in_q;
  assign ctrl.busy      = busy_q;
  assign ctrl.done      = done_q;
  assign ctrl.pass      = pass_q;
  assign ctrl.err_count = err_q;

endmodule
